// File: rtl/uart_transmit_pkg.sv
// Shared UART constants and helpers, reused by the transmitter and receiver.
`timescale 1ns/1ps
package uart_transmit_pkg;

    localparam int   FrameBits = 10;
    localparam logic StartBit  = 1'b0;
    localparam logic StopBit   = 1'b1;
    localparam logic IdleLevel = 1'b1;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // Ceiling log2, never less than 1 so it can size a counter directly.
    function automatic int log2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with a fall-through head so the frame can load on the pop edge.
`timescale 1ns/1ps
module uart_tx_fifo
    import uart_transmit_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [Width-1:0]       InData,
    input  logic                   InValid,
    output logic                   InReady,
    output logic [Width-1:0]       OutData,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [log2(Depth):0]   Count
);

    localparam int PtrW = log2(Depth);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

    logic [Width-1:0] mem_reg [Depth];
    logic [PtrW-1:0]  wr_ptr_reg;
    logic [PtrW-1:0]  rd_ptr_reg;
    logic [PtrW:0]    count_reg;
    logic             push;
    logic             pop;

    assign InReady  = (count_reg != FullCount);
    assign OutValid = (count_reg != '0);
    assign OutData  = mem_reg[rd_ptr_reg];
    assign Count    = count_reg;
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never visible because count gates them.
    always_ff @(posedge Clock) begin
        if (push) mem_reg[wr_ptr_reg] <= InData;
    end

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter: ready/valid byte input, FIFO buffering, registered serial output.
`timescale 1ns/1ps
module uart_transmit
    import uart_transmit_pkg::*;
#(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200,
    parameter int FifoDepth = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SOut,
    output logic       TxBusy
);

    localparam int SymbolEdgeTime = ClockFreq / BaudRate;
    localparam int ClkCntW        = log2(SymbolEdgeTime);
    localparam int BitCntW        = log2(FrameBits + 1);
    localparam int FifoCntW       = log2(FifoDepth) + 1;
    localparam logic [ClkCntW-1:0] LastTick = ClkCntW'(SymbolEdgeTime - 1);
    localparam logic [BitCntW-1:0] FrameLen = BitCntW'(FrameBits);

    logic [FifoCntW-1:0]  fifo_count;
    logic [7:0]           fifo_data;
    logic                 fifo_valid;
    logic                 fifo_pop;

    tx_state_t            state_reg, state_next;
    logic [FrameBits-1:0] tx_shift_reg, tx_shift_next;
    logic [BitCntW-1:0]   bit_counter_reg, bit_counter_next;
    logic [ClkCntW-1:0]   clock_counter_reg, clock_counter_next;

    uart_tx_fifo #(
        .Width (8),
        .Depth (FifoDepth)
    ) u_fifo (
        .Clock    (Clock),
        .Reset    (Reset),
        .InData   (DataIn),
        .InValid  (DataInValid),
        .InReady  (DataInReady),
        .OutData  (fifo_data),
        .OutValid (fifo_valid),
        .OutReady (fifo_pop),
        .Count    (fifo_count)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg         <= TX_IDLE;
            tx_shift_reg      <= {FrameBits{IdleLevel}};
            bit_counter_reg   <= '0;
            clock_counter_reg <= '0;
        end else begin
            state_reg         <= state_next;
            tx_shift_reg      <= tx_shift_next;
            bit_counter_reg   <= bit_counter_next;
            clock_counter_reg <= clock_counter_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        tx_shift_next      = tx_shift_reg;
        bit_counter_next   = bit_counter_reg;
        clock_counter_next = clock_counter_reg;
        fifo_pop           = 1'b0;
        case (state_reg)
            TX_IDLE: begin
                if (fifo_valid) begin
                    fifo_pop           = 1'b1;
                    tx_shift_next      = {StopBit, fifo_data, StartBit};
                    bit_counter_next   = FrameLen;
                    clock_counter_next = '0;
                    state_next         = TX_SEND;
                end
            end
            TX_SEND: begin
                if (clock_counter_reg == LastTick) begin
                    clock_counter_next = '0;
                    tx_shift_next      = {IdleLevel, tx_shift_reg[FrameBits-1:1]};
                    bit_counter_next   = bit_counter_reg - 1'b1;
                    // End of the stop bit: chain the next frame with no idle gap.
                    if (bit_counter_reg == BitCntW'(1)) begin
                        if (fifo_valid) begin
                            fifo_pop         = 1'b1;
                            tx_shift_next    = {StopBit, fifo_data, StartBit};
                            bit_counter_next = FrameLen;
                        end else begin
                            state_next = TX_IDLE;
                        end
                    end
                end else begin
                    clock_counter_next = clock_counter_reg + 1'b1;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    // The shift register idles all-ones, so bit 0 is a glitch-free line driver.
    assign SOut   = tx_shift_reg[0];
    assign TxBusy = (state_reg == TX_SEND) || (fifo_count != '0);

endmodule
